seq_detector_param: RTL

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

---
 rtl/seq_detector_param.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Serial pattern detector with a runtime-loadable PAT_W-bit
//            pattern, overlapping / non-overlapping detection, a registered
//            one-cycle match pulse and a saturating match counter.
// Ports    : clock        - single clock, rising edge
//            reset        - synchronous, active-low reset
//            input_D      - serial data bit
//            data_valid   - input_D is offered this cycle
//            pattern_in   - new pattern, MSB is the first bit expected
//            load_pattern - capture pattern_in, restart fill (drops input_D)
//            overlap_en   - 1 = overlapping, 0 = non-overlapping detection
//            clear_count  - zero match_count (wins over a coincident match)
//            match        - registered detection pulse, one cycle
//            match_count  - saturating count of matches
//            fill_level   - number of valid history bits (0..PAT_W)
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               PAT_W     = 5,
    parameter int               CNT_W     = 8,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(5'b10100)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         input_D,
    input  logic                         data_valid,
    input  logic [PAT_W-1:0]             pattern_in,
    input  logic                         load_pattern,
    input  logic                         overlap_en,
    input  logic                         clear_count,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(PAT_W+1)-1:0]   fill_level
);

    localparam int                C_FILL_W   = $clog2(PAT_W + 1);
    localparam logic [C_FILL_W-1:0] C_FILL_FULL = C_FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

    // IDLE: no valid bits, FILL: partially filled, ARMED: history full.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [PAT_W-1:0]      pattern_q, pattern_d;
    logic [PAT_W-1:0]      history_q, history_d;
    logic [C_FILL_W-1:0]   fill_q,    fill_d;
    logic                  match_q,   match_d;
    logic [CNT_W-1:0]      count_q,   count_d;

    logic                  w_accept;
    logic [PAT_W-1:0]      w_hist_nxt;
    logic [C_FILL_W-1:0]   w_fill_inc;
    logic                  w_hit;

    always_comb begin
        // A load cycle owns the datapath: the offered bit is dropped.
        w_accept   = data_valid && !load_pattern;
        w_hist_nxt = (history_q << 1) | PAT_W'(input_D);
        // Fill saturates once the history is full.
        w_fill_inc = (state_q == ARMED) ? fill_q : (fill_q + C_FILL_W'(1));
        // Every accepted bit is compared; fill guards against stale history.
        w_hit      = w_accept && (w_hist_nxt == pattern_q) && (w_fill_inc == C_FILL_FULL);

        pattern_d  = pattern_q;
        history_d  = history_q;
        fill_d     = fill_q;
        match_d    = w_hit;
        count_d    = count_q;

        if (load_pattern) begin
            pattern_d = pattern_in;
            fill_d    = '0;
        end else if (w_accept) begin
            history_d = w_hist_nxt;
            // Non-overlapping mode restarts the fill so the next match needs
            // a full fresh pattern's worth of bits.
            fill_d    = (w_hit && !overlap_en) ? '0 : w_fill_inc;
        end

        if (clear_count) begin
            count_d = '0;
        end else if (w_hit && (count_q != C_CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end

        if (fill_d == '0) begin
            state_d = IDLE;
        end else if (fill_d == C_FILL_FULL) begin
            state_d = ARMED;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            pattern_q <= RESET_PAT;
            history_q <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign fill_level  = fill_q;

endmodule
`default_nettype wire
